// File: rtl/vic_pkg.sv
// Shared defaults and FSM state type for the vectored interrupt dispatcher.
package vic_pkg;

    localparam int unsigned VIC_N_SRC  = 31;
    localparam int unsigned VIC_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } vic_state_t;

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module vic_prio_enc #(
    parameter int unsigned N_SRC  = 31,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [N_SRC-1:0]  i_vec,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_vld
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = ADDR_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vic_dispatch.sv
// Vectored interrupt dispatcher: picks the lowest eligible source, requests the
// CPU, tracks in-service sources through ACK/EOI and flags spurious handshakes.
// Optional macro VIC_NEST_EN enables preemption of a running service by a
// lower-index (higher-priority) source.
module vic_dispatch
    import vic_pkg::*;
#(
    parameter int unsigned N_SRC  = VIC_N_SRC,
    parameter int unsigned ADDR_W = VIC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [N_SRC-1:0]  i_pend,
    input  logic [N_SRC-1:0]  i_mask,
    input  logic              i_ack,
    input  logic              i_eoi,
    output logic              o_irq,
    output logic [ADDR_W-1:0] o_irq_addr,
    output logic [N_SRC-1:0]  o_clr,
    output logic              o_spur
);

    vic_state_t        r_state;
    logic              r_irq;
    logic [ADDR_W-1:0] r_addr;
    logic [N_SRC-1:0]  r_clr;
    logic              r_spur;
    logic [N_SRC-1:0]  r_insvc;

    logic [N_SRC-1:0]  w_elig;
    logic [ADDR_W-1:0] w_elig_idx;
    logic              w_elig_vld;
    logic [ADDR_W-1:0] w_insvc_idx;
    logic              w_insvc_vld;
    logic [N_SRC-1:0]  w_insvc_rest;
    logic [N_SRC-1:0]  w_addr_oh;
    logic              w_preempt;

    // Lowest set index of an arbitrary vector, used for the post-EOI vector.
    function automatic logic [ADDR_W-1:0] f_lowest(input logic [N_SRC-1:0] v);
        f_lowest = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = ADDR_W'(i);
        end
    endfunction

    assign w_elig       = i_pend & ~i_mask;
    assign w_insvc_rest = r_insvc & (r_insvc - N_SRC'(1));
    assign w_addr_oh    = N_SRC'(1) << r_addr;

    vic_prio_enc #(.N_SRC(N_SRC), .ADDR_W(ADDR_W)) u_enc_elig (
        .i_vec (w_elig),
        .o_idx (w_elig_idx),
        .o_vld (w_elig_vld)
    );

    vic_prio_enc #(.N_SRC(N_SRC), .ADDR_W(ADDR_W)) u_enc_insvc (
        .i_vec (r_insvc),
        .o_idx (w_insvc_idx),
        .o_vld (w_insvc_vld)
    );

`ifdef VIC_NEST_EN
    // A strictly higher-priority eligible source interrupts the running service.
    assign w_preempt = i_en && w_elig_vld && (w_elig_idx < w_insvc_idx);
`else
    assign w_preempt = 1'b0;
`endif

    // Dispatch FSM with registered request, vector, clear and spurious outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_addr  <= '0;
            r_clr   <= '0;
            r_spur  <= 1'b0;
            r_insvc <= '0;
        end else begin
            r_clr  <= '0;
            r_spur <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_ack || i_eoi) r_spur <= 1'b1;
                    if (i_en && w_elig_vld) begin
                        r_addr  <= w_elig_idx;
                        r_irq   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_eoi) r_spur <= 1'b1;
                    if (i_ack) begin
                        r_clr   <= w_addr_oh;
                        r_insvc <= r_insvc | w_addr_oh;
                        r_irq   <= 1'b0;
                        r_state <= ST_SERVICE;
                    end else if (!i_en) begin
                        // A withdrawn preemption falls back to the interrupted service.
                        r_irq <= 1'b0;
                        if (w_insvc_vld) begin
                            r_addr  <= w_insvc_idx;
                            r_state <= ST_SERVICE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SERVICE: begin
                    if (i_ack) r_spur <= 1'b1;
                    if (i_eoi) begin
                        r_insvc <= w_insvc_rest;
                        if (|w_insvc_rest) r_addr  <= f_lowest(w_insvc_rest);
                        else               r_state <= ST_IDLE;
                    end else if (w_preempt) begin
                        r_addr  <= w_elig_idx;
                        r_irq   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_irq      = r_irq;
    assign o_irq_addr = r_addr;
    assign o_clr      = r_clr;
    assign o_spur     = r_spur;

endmodule

// File: tb/tb_vic_dispatch.sv
// Scoreboard bench for vic_dispatch: the driver plays detector and CPU and
// queues the events it expects; the monitor pops and compares DUT events.
module tb_vic_dispatch;

    localparam int N  = 31;
    localparam int AW = 5;

    localparam logic [1:0] EV_IRQ  = 2'd0;
    localparam logic [1:0] EV_CLR  = 2'd1;
    localparam logic [1:0] EV_SPUR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic          i_clk;
    logic          i_rst;
    logic          i_en;
    logic [N-1:0]  i_pend;
    logic [N-1:0]  i_mask;
    logic          i_ack;
    logic          i_eoi;
    logic          o_irq;
    logic [AW-1:0] o_irq_addr;
    logic [N-1:0]  o_clr;
    logic          o_spur;

    ev_t           exp_q[$];
    logic [N-1:0]  tb_pend;
    int            vectors;
    int            miscompares;
    logic          prev_irq;
    logic [AW-1:0] prev_addr;

    vic_dispatch #(.N_SRC(N), .ADDR_W(AW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_pend     (i_pend),
        .i_mask     (i_mask),
        .i_ack      (i_ack),
        .i_eoi      (i_eoi),
        .o_irq      (o_irq),
        .o_irq_addr (o_irq_addr),
        .o_clr      (o_clr),
        .o_spur     (o_spur)
    );

    always #5 i_clk = ~i_clk;

    // Reference: the lowest index of the eligible set wins.
    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        logic [31:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    task automatic push(input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_event(input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: kind %0d val 0x%0h, none expected at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                miscompares++;
                $display("FAIL event: got kind %0d val 0x%0h expected kind %0d val 0x%0h at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: every DUT event is matched against the head of the queue.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_irq && !prev_irq) check_event(EV_IRQ, 32'(o_irq_addr));
            if (o_irq && prev_irq)  chk("addr_stable", 32'(o_irq_addr), 32'(prev_addr));
            if (o_clr != '0)        check_event(EV_CLR, 32'(o_clr));
            if (o_spur)             check_event(EV_SPUR, 32'd1);
        end
        prev_irq  <= o_irq;
        prev_addr <= o_irq_addr;
    end

    // One full request/ack/eoi transaction, entered and left with i_en low and the DUT idle.
    task automatic run_txn(input logic [N-1:0] add_bits, input logic [N-1:0] mask,
                           input int raise_idx, input bit both, input bit eoi_req,
                           input bit spur_ack, input bit withdraw, input bit spur_idle,
                           input int extra_wait);
        int x;
        int r;
        tb_pend = tb_pend | add_bits;
        i_pend  = tb_pend;
        i_mask  = mask;
        x = lowest(tb_pend & ~mask);
        if (x < 0) begin
            i_en = 1'b1;
            repeat (3) tick();
            i_en = 1'b0;
            tick();
            return;
        end
        push(EV_IRQ, 32'(x));
        i_en = 1'b1;
        tick();
        chk("irq_latency", 32'(o_irq), 32'd1);
        r = raise_idx;
`ifdef VIC_NEST_EN
        if (r >= 0 && r < x) r = -1;
`endif
        if (r >= 0) begin
            tb_pend[r] = 1'b1;
            i_pend = tb_pend;
        end
        repeat (extra_wait) tick();
        if (eoi_req) begin
            push(EV_SPUR, 32'd1);
            i_eoi = 1'b1;
            tick();
            i_eoi = 1'b0;
        end
        if (withdraw) begin
            i_en = 1'b0;
            tick();
            chk("withdraw_irq", 32'(o_irq), 32'd0);
            tick();
            return;
        end
        push(EV_CLR, onehot(x));
        if (both) push(EV_SPUR, 32'd1);
        i_ack = 1'b1;
        i_eoi = both;
        tick();
        i_ack = 1'b0;
        i_eoi = 1'b0;
        chk("irq_drop_on_ack", 32'(o_irq), 32'd0);
        tb_pend[x] = 1'b0;
        i_pend = tb_pend;
        if (spur_ack) begin
            push(EV_SPUR, 32'd1);
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
        end
        i_eoi = 1'b1;
        tick();
        i_eoi = 1'b0;
        i_en  = 1'b0;
        tick();
        if (spur_idle) begin
            push(EV_SPUR, 32'd1);
            i_eoi = 1'b1;
            tick();
            i_eoi = 1'b0;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        i_clk = 1'b0;
        i_rst = 1'b1;
        i_en = 1'b0;
        i_pend = '0;
        i_mask = '0;
        i_ack = 1'b0;
        i_eoi = 1'b0;
        tb_pend = '0;
        vectors = 0;
        miscompares = 0;
        repeat (3) tick();
        chk("rst_irq",  32'(o_irq), 32'd0);
        chk("rst_addr", 32'(o_irq_addr), 32'd0);
        chk("rst_clr",  32'(o_clr), 32'd0);
        chk("rst_spur", 32'(o_spur), 32'd0);
        i_rst = 1'b0;
        tick();

        // Stray handshakes while idle are spurious.
        push(EV_SPUR, 32'd1);
        i_eoi = 1'b1; tick(); i_eoi = 1'b0; tick();
        push(EV_SPUR, 32'd1);
        i_ack = 1'b1; tick(); i_ack = 1'b0; tick();

        // Sources 4 and 5 pending, source 1 arrives mid-request, then ack together with eoi.
        run_txn(31'h30, '0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        chk("pend_after_first", 32'(tb_pend), 32'h22);
        run_txn('0, '0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        run_txn('0, '0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Masked source ignored, then withdrawal leaves it pending.
        run_txn(31'h4, 31'h4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_txn(31'h8, '0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run_txn('0, 31'h4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_txn('0, '0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Highest index source.
        run_txn(31'h4000_0000, '0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Service of source 7 while source 2 arrives.
        tb_pend = 31'h80; i_pend = tb_pend; i_mask = '0;
        push(EV_IRQ, 32'd7);
        i_en = 1'b1; tick();
        push(EV_CLR, 32'h80);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tb_pend[7] = 1'b0; tb_pend[2] = 1'b1; i_pend = tb_pend;
`ifdef VIC_NEST_EN
        push(EV_IRQ, 32'd2);
        tick();
        chk("nest_irq", 32'(o_irq), 32'd1);
        chk("nest_addr", 32'(o_irq_addr), 32'd2);
        push(EV_CLR, 32'h4);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tb_pend[2] = 1'b0; i_pend = tb_pend;
        i_eoi = 1'b1; tick(); i_eoi = 1'b0;
        chk("nest_resume_addr", 32'(o_irq_addr), 32'd7);
        chk("nest_resume_irq", 32'(o_irq), 32'd0);
        i_eoi = 1'b1; tick(); i_eoi = 1'b0; i_en = 1'b0; tick();
`else
        repeat (4) tick();
        chk("no_nest_irq", 32'(o_irq), 32'd0);
        push(EV_IRQ, 32'd2);
        i_eoi = 1'b1; tick(); i_eoi = 1'b0;
        chk("idle_gap_irq", 32'(o_irq), 32'd0);
        tick();
        chk("after_eoi_irq", 32'(o_irq), 32'd1);
        chk("after_eoi_addr", 32'(o_irq_addr), 32'd2);
        push(EV_CLR, 32'h4);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tb_pend[2] = 1'b0; i_pend = tb_pend;
        i_eoi = 1'b1; tick(); i_eoi = 1'b0; i_en = 1'b0; tick();
`endif

        // Reset in SERVICE abandons the transaction; source 3 is still pending.
        tb_pend = 31'h8; i_pend = tb_pend;
        push(EV_IRQ, 32'd3);
        i_en = 1'b1; tick();
        push(EV_CLR, 32'h8);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tick();
        i_rst = 1'b1; tick();
        chk("svc_rst_irq",  32'(o_irq), 32'd0);
        chk("svc_rst_addr", 32'(o_irq_addr), 32'd0);
        chk("svc_rst_clr",  32'(o_clr), 32'd0);
        chk("svc_rst_spur", 32'(o_spur), 32'd0);
        push(EV_IRQ, 32'd3);
        i_rst = 1'b0; tick();
        chk("rearm_irq",  32'(o_irq), 32'd1);
        chk("rearm_addr", 32'(o_irq_addr), 32'd3);
        push(EV_CLR, 32'h8);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tb_pend[3] = 1'b0; i_pend = tb_pend;
        i_eoi = 1'b1; tick(); i_eoi = 1'b0; i_en = 1'b0; tick();

        // Randomized transactions.
        for (int t = 0; t < 80; t++) begin
            logic [N-1:0] add;
            logic [N-1:0] msk;
            add = N'($urandom) & N'($urandom) & N'($urandom);
            msk = N'($urandom) & N'($urandom);
            run_txn(add, msk,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)));
        end

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
